// File: rtl/if_axi_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage (package ifu_pkg).
package ifu_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_e;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [31:0] INST_NOP       = 32'h00000013;
  localparam int unsigned PC_STEP        = 4;

endpackage

// File: rtl/if_axi_fetch.sv
// Instruction fetch: owns the PC, issues single-beat AXI4 reads, holds pc/inst for IF/ID.
// Optional macro IFU_RESP_CHK_EN: error responses become NOPs and raise sticky fetch_err/fetch_err_pc.
module if_axi_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ID_W     = 4,
  parameter logic [ID_W-1:0]   FETCH_ID = '0,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid,
  output logic              fetch_wait,
  output logic [ADDR_W-1:0] araddr,
  output logic [ID_W-1:0]   arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [ID_W-1:0]   rid,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
`ifdef IFU_RESP_CHK_EN
  output logic              fetch_err,
  output logic [ADDR_W-1:0] fetch_err_pc,
`endif
  output logic              rready
);

  // state | meaning
  // IDLE  | one cycle after reset before the first request
  // ADDR  | arvalid high, waiting for arready
  // DATA  | rready high, waiting for the single beat
  // HOLD  | instruction presented to IF/ID until consumed or redirected

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d, kill_q, kill_d;
`ifdef IFU_RESP_CHK_EN
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_pc_q, err_pc_d;
`endif

  logic unused_ok;
  assign unused_ok = ^{rid, rresp};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      inst_q    <= '0;
      valid_q   <= 1'b0;
      kill_q    <= 1'b0;
`ifdef IFU_RESP_CHK_EN
      err_q     <= 1'b0;
      err_pc_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      inst_q    <= inst_d;
      valid_q   <= valid_d;
      kill_q    <= kill_d;
`ifdef IFU_RESP_CHK_EN
      err_q     <= err_d;
      err_pc_q  <= err_pc_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    inst_d    = inst_q;
    valid_d   = valid_q;
    kill_d    = kill_q;
`ifdef IFU_RESP_CHK_EN
    err_d     = err_q;
    err_pc_d  = err_pc_q;
`endif
    case (state_q)
      IDLE: begin
        if (redirect) pc_d = redirect_pc;
        state_d = ADDR;
      end
      ADDR: begin
        // The request cannot be withdrawn, so a redirect only marks its beat for discard.
        if (redirect) begin
          kill_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
        if (arready) state_d = DATA;
      end
      DATA: begin
        if (rvalid && rlast) begin
          if (redirect || kill_q) begin
            pc_d    = redirect ? redirect_pc : pend_pc_q;
            kill_d  = 1'b0;
            state_d = ADDR;
          end else begin
            inst_d  = rdata;
            valid_d = 1'b1;
            state_d = HOLD;
`ifdef IFU_RESP_CHK_EN
            if (rresp != AXI_RESP_OKAY) begin
              inst_d = DATA_W'(INST_NOP);
              err_d  = 1'b1;
              if (!err_q) err_pc_d = pc_q;
            end
`endif
          end
        end else if (redirect) begin
          kill_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
      end
      HOLD: begin
        // Redirect wins over a simultaneous consume; the held instruction is dropped.
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = ADDR;
        end else if (!pipe_stall) begin
          pc_d    = pc_q + ADDR_W'(PC_STEP);
          valid_d = 1'b0;
          state_d = ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arvalid = 1'b0;
    rready  = 1'b0;
    case (state_q)
      ADDR:    arvalid = 1'b1;
      DATA:    rready  = 1'b1;
      default: ;
    endcase
  end

  assign araddr     = pc_q;
  assign arid       = FETCH_ID;
  assign arlen      = 8'd0;
  assign arsize     = AXI_SIZE_4B;
  assign arburst    = AXI_BURST_INCR;
  assign if_pc      = pc_q;
  assign if_inst    = inst_q;
  assign if_valid   = valid_q;
  assign fetch_wait = ~valid_q;
`ifdef IFU_RESP_CHK_EN
  assign fetch_err    = err_q;
  assign fetch_err_pc = err_pc_q;
`endif

endmodule

// File: tb/tb_if_axi_fetch.sv
// Bench for if_axi_fetch: AXI slave model plus an architectural next-PC model.
module tb_if_axi_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] if_pc, if_inst, araddr, rdata = '0;
  logic        if_valid, fetch_wait, arvalid, rready;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b1;
  logic [3:0]  arid, rid = '0;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp = '0;
`ifdef IFU_RESP_CHK_EN
  logic        fetch_err;
  logic [31:0] fetch_err_pc;
`endif

  if_axi_fetch dut (
    .clk(clk), .rst(rst), .pipe_stall(pipe_stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .fetch_wait(fetch_wait),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
`ifdef IFU_RESP_CHK_EN
    .fetch_err(fetch_err), .fetch_err_pc(fetch_err_pc),
`endif
    .rready(rready)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_fail = 0;
  logic [31:0] exp_pc = '0;
  int          deliveries = 0;
  bit          have_req = 0;
  logic [31:0] req_addr = '0;
  int          rdelay = 0, s_fast = 1, s_rfix = -1, ar_hold = 0;
  logic [31:0] err_addr = 32'hFFFF_FFF0;
  bit          ar_pend = 0;
  logic [31:0] ar_pend_addr = '0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    return (a * 32'h01000193) ^ 32'h13572468;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
`ifdef IFU_RESP_CHK_EN
    if (a == err_addr) return 32'h00000013;
`endif
    return mem(a);
  endfunction

  // Entered and left at a negedge: check, drive slave, update model, cross one posedge.
  task automatic tick();
    bit ar_hs, r_hs;
    n_cmp++;
    if (fetch_wait !== ~if_valid) begin
      n_fail++; $display("FAIL fetch_wait: got %b want %b", fetch_wait, ~if_valid);
    end
    if (if_valid === 1'b1) begin
      n_cmp++;
      if (if_pc !== exp_pc) begin n_fail++; $display("FAIL model_pc: got %h want %h", if_pc, exp_pc); end
      n_cmp++;
      if (if_inst !== exp_inst(exp_pc)) begin
        n_fail++; $display("FAIL model_inst: got %h want %h", if_inst, exp_inst(exp_pc));
      end
    end
    if (ar_pend) begin
      n_cmp++;
      if (arvalid !== 1'b1 || araddr !== ar_pend_addr) begin
        n_fail++; $display("FAIL ar_stable: got %b/%h want 1/%h", arvalid, araddr, ar_pend_addr);
      end
    end
    if (have_req) begin
      n_cmp++;
      if (arvalid !== 1'b0) begin n_fail++; $display("FAIL one_outstanding: arvalid got %b want 0", arvalid); end
    end
    arready = 1'b0;
    if (arvalid === 1'b1 && !have_req) begin
      if (ar_hold > 0) ar_hold--;
      else arready = (s_fast != 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    rvalid = 1'b0; rresp = 2'b00; rdata = $urandom; rid = '0;
    if (have_req) begin
      if (rdelay == 0) begin
        rvalid = 1'b1; rdata = mem(req_addr);
        rresp = (req_addr == err_addr) ? 2'b10 : 2'b00;
      end else rdelay--;
    end
    ar_hs = (arvalid === 1'b1) && arready;
    r_hs  = rvalid && (rready === 1'b1);
    if (redirect) exp_pc = redirect_pc;
    else if (if_valid === 1'b1 && !pipe_stall) begin exp_pc = exp_pc + 32'd4; deliveries++; end
    if (r_hs) have_req = 0;
    if (ar_hs) begin
      have_req = 1; req_addr = araddr;
      rdelay = (s_rfix >= 0) ? s_rfix : ((s_fast != 0) ? 0 : $urandom_range(0, 3));
    end
    ar_pend = (arvalid === 1'b1) && !arready;
    ar_pend_addr = araddr;
    @(posedge clk);
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic wait_arvalid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (arvalid === 1'b1) break;
      tick();
    end
    n_cmp++;
    if (arvalid !== 1'b1) begin n_fail++; $display("FAIL wait_arvalid: got %b want 1 (timeout)", arvalid); end
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (if_valid === 1'b1) break;
      tick();
    end
    n_cmp++;
    if (if_valid !== 1'b1) begin n_fail++; $display("FAIL wait_valid: got %b want 1 (timeout)", if_valid); end
  endtask

  task automatic reset_assert();
    rst = 1'b1; pipe_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    arready = 1'b0; rvalid = 1'b0; have_req = 0; ar_pend = 0; ar_hold = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_release();
    rst = 1'b0; exp_pc = 32'h0;
  endtask

  task automatic test_reset();
    reset_assert();
    n_cmp++;
    if ({if_valid, arvalid, rready, fetch_wait} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0001", {if_valid, arvalid, rready, fetch_wait});
    end
    n_cmp++;
    if (if_inst !== 32'h0 || if_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", if_inst, if_pc);
    end
    n_cmp++;
    if (arlen !== 8'd0 || arsize !== 3'b010 || arburst !== 2'b01 || arid !== 4'd0) begin
      n_fail++; $display("FAIL ar_const: got %h/%b/%b/%h want 00/010/01/0", arlen, arsize, arburst, arid);
    end
`ifdef IFU_RESP_CHK_EN
    n_cmp++;
    if (fetch_err !== 1'b0 || fetch_err_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_err: got %b/%h want 0/0", fetch_err, fetch_err_pc);
    end
`endif
    reset_release();
  endtask

  task automatic test_basic();
    s_fast = 1; s_rfix = -1;
    wait_arvalid(5);
    n_cmp++;
    if (araddr !== 32'h0) begin n_fail++; $display("FAIL first_araddr: got %h want 0", araddr); end
    tick(); tick();
    n_cmp++;
    if (if_valid !== 1'b1 || if_inst !== 32'h00500093 || if_pc !== 32'h0) begin
      n_fail++; $display("FAIL first_inst: got %b/%h/%h want 1/00500093/0", if_valid, if_inst, if_pc);
    end
    tick();
    n_cmp++;
    if (arvalid !== 1'b1 || araddr !== 32'h4) begin
      n_fail++; $display("FAIL next_araddr: got %b/%h want 1/4", arvalid, araddr);
    end
  endtask

  task automatic test_stall();
    logic [31:0] p0, i0;
    wait_valid(20);
    p0 = if_pc; i0 = if_inst;
    n_cmp++;
    if (p0 !== 32'h4) begin n_fail++; $display("FAIL stall_pc: got %h want 4", p0); end
    pipe_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== p0 || if_inst !== i0 || arvalid !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold: got %b/%h/%h/%b want 1/%h/%h/0", if_valid, if_pc, if_inst, arvalid, p0, i0);
      end
    end
    pipe_stall = 1'b0;
    tick();
    n_cmp++;
    if (arvalid !== 1'b1 || araddr !== p0 + 32'd4) begin
      n_fail++; $display("FAIL stall_release: got %b/%h want 1/%h", arvalid, araddr, p0 + 32'd4);
    end
  endtask

  task automatic test_redirect_data();
    s_rfix = 2;
    for (int i = 0; i < 10; i++) begin
      if (rready === 1'b1) break;
      tick();
    end
    n_cmp++;
    if (rready !== 1'b1 || araddr !== 32'h8) begin
      n_fail++; $display("FAIL redir_data_setup: got %b/%h want 1/8", rready, araddr);
    end
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    s_rfix = -1;
    for (int i = 0; i < 12; i++) begin
      if (arvalid === 1'b1) break;
      n_cmp++;
      if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_data_discard: got %b want 0", if_valid); end
      tick();
    end
    n_cmp++;
    if (arvalid !== 1'b1 || araddr !== 32'h100) begin
      n_fail++; $display("FAIL redir_data_addr: got %b/%h want 1/100", arvalid, araddr);
    end
  endtask

  task automatic test_redirect_hold();
    wait_valid(20);
    n_cmp++;
    if (if_pc !== 32'h100) begin n_fail++; $display("FAIL redir_hold_pc: got %h want 100", if_pc); end
    pipe_stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    n_cmp++;
    if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_hold_drop: got %b want 0", if_valid); end
    wait_arvalid(5);
    n_cmp++;
    if (araddr !== 32'h200) begin n_fail++; $display("FAIL redir_hold_addr: got %h want 200", araddr); end
    wait_valid(20);
    n_cmp++;
    if (if_pc !== 32'h200) begin n_fail++; $display("FAIL redir_hold_deliver: got %h want 200", if_pc); end
  endtask

  task automatic test_ar_hold();
    pipe_stall = 1'b0; ar_hold = 4;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (arvalid !== 1'b1 || araddr !== 32'h204) begin
        n_fail++; $display("FAIL ar_hold: got %b/%h want 1/204", arvalid, araddr);
      end
      tick();
    end
    tick();
    n_cmp++;
    if (arvalid !== 1'b0 || rready !== 1'b1) begin
      n_fail++; $display("FAIL ar_accept: got %b/%b want 0/1", arvalid, rready);
    end
  endtask

  task automatic test_async_reset();
    s_rfix = 3;
    wait_valid(20);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (rready === 1'b1) break;
      tick();
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({arvalid, rready, if_valid} !== 3'b000) begin
      n_fail++; $display("FAIL async_reset: got %b want 000", {arvalid, rready, if_valid});
    end
    reset_assert();
    reset_release();
    s_rfix = -1;
    wait_arvalid(5);
    n_cmp++;
    if (araddr !== 32'h0) begin n_fail++; $display("FAIL reset_refetch: got %h want 0", araddr); end
    wait_valid(20);
    n_cmp++;
    if (if_pc !== 32'h0 || if_inst !== 32'h00500093) begin
      n_fail++; $display("FAIL reset_redeliver: got %h/%h want 0/00500093", if_pc, if_inst);
    end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    wait_valid(20);
    n_cmp++;
    if (if_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got %h want fffffffc", if_pc); end
    pipe_stall = 1'b0;
    tick();
    n_cmp++;
    if (arvalid !== 1'b1 || araddr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_addr: got %b/%h want 1/0", arvalid, araddr);
    end
  endtask

  task automatic test_random();
    int d0;
    d0 = deliveries; s_fast = 0;
    for (int i = 0; i < 800; i++) begin
      pipe_stall = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = 32'($urandom_range(0, 255)) * 32'd4;
      tick();
    end
    pipe_stall = 1'b0; s_fast = 1;
    n_cmp++;
    if (deliveries - d0 < 20) begin
      n_fail++; $display("FAIL random_progress: got %0d deliveries want >= 20", deliveries - d0);
    end
  endtask

`ifdef IFU_RESP_CHK_EN
  task automatic test_resp_err();
    reset_assert();
    reset_release();
    err_addr = 32'hC; s_fast = 1; s_rfix = -1;
    for (int i = 0; i < 40; i++) begin
      if (if_valid === 1'b1 && if_pc === 32'hC) break;
      tick();
    end
    n_cmp++;
    if (if_pc !== 32'hC || if_inst !== 32'h00000013 || fetch_err !== 1'b1 || fetch_err_pc !== 32'hC) begin
      n_fail++; $display("FAIL resp_err: got %h/%h/%b/%h want c/00000013/1/c", if_pc, if_inst, fetch_err, fetch_err_pc);
    end
    tick();
    wait_valid(20);
    n_cmp++;
    if (if_pc !== 32'h10 || if_inst !== mem(32'h10) || fetch_err !== 1'b1 || fetch_err_pc !== 32'hC) begin
      n_fail++; $display("FAIL resp_err_sticky: got %h/%h/%b/%h want 10/%h/1/c", if_pc, if_inst, fetch_err, fetch_err_pc, mem(32'h10));
    end
    err_addr = 32'hFFFF_FFF0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_data();
    test_redirect_hold();
    test_ar_hold();
    test_async_reset();
    test_wrap();
    test_random();
`ifdef IFU_RESP_CHK_EN
    test_resp_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
